// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : Per-bit two-flop synchroniser and debouncer for the raw board
//                slide switches. Produces a clean level per bit plus one-cycle
//                rise/fall pulses, all taken directly from flops.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_debounce #(
    parameter int N        = 10,
    parameter int DB_COUNT = 16
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic [N-1:0] SwIn,
    output logic [N-1:0] Switches,
    output logic [N-1:0] SwRise,
    output logic [N-1:0] SwFall
);

    // Counter only needs to reach DB_COUNT-1; acceptance happens on that edge.
    localparam int                 c_CNT_W   = $clog2(DB_COUNT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_COUNT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    generate
        if (DB_COUNT < 2 || N < 1) begin : g_param_check
            $error("switch_debounce: requires DB_COUNT >= 2 and N >= 1");
        end
    endgenerate

    logic [N-1:0]         r_sync1;
    logic [N-1:0]         r_sync2;
    logic [N-1:0]         r_level;
    logic [N-1:0]         r_rise;
    logic [N-1:0]         r_fall;
    logic [c_CNT_W-1:0]   r_cnt [N];

    // Two-flop synchroniser bringing the asynchronous switches into Clock domain.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= SwIn;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit stability counter; a new level is accepted only after DB_COUNT
    // consecutive disagreeing cycles, and the edge pulses fire on that same edge.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    // Any return to the accepted level restarts the count.
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_MAX) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                    r_rise[i]  <= r_sync2[i];
                    r_fall[i]  <= ~r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

    assign Switches = r_level;
    assign SwRise   = r_rise;
    assign SwFall   = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debounce
//  Description : Self-checking bench for switch_debounce. A reference model
//                built on a sample-history window queues the expected outputs
//                for every clock edge; a monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_switch_debounce;

    localparam int N        = 10;
    localparam int DB_COUNT = 4;
    localparam int HIST     = DB_COUNT + 2;

    logic         Clock = 1'b0;
    logic         nReset;
    logic [N-1:0] SwIn;
    logic [N-1:0] Switches;
    logic [N-1:0] SwRise;
    logic [N-1:0] SwFall;

    int checks   = 0;
    int failures = 0;

    switch_debounce #(.N(N), .DB_COUNT(DB_COUNT)) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .SwIn     (SwIn),
        .Switches (Switches),
        .SwRise   (SwRise),
        .SwFall   (SwFall)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A switch value sampled at edge t is first seen by the debouncer at edge
    // t+2. The level flips at an edge when the DB_COUNT samples it has seen
    // most recently all hold the opposite value.
    logic [N-1:0] hist [$];
    logic [N-1:0] m_level;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    logic [3*N-1:0] exp_q [$];

    always @(posedge Clock) begin
        m_rise = '0;
        m_fall = '0;
        if (!nReset) begin
            hist = {};
            for (int k = 0; k < HIST; k++) hist.push_back('0);
            m_level = '0;
        end else begin
            hist.push_front(SwIn);
            void'(hist.pop_back());
            for (int b = 0; b < N; b++) begin
                bit all_opp;
                all_opp = 1'b1;
                for (int k = 2; k <= DB_COUNT + 1; k++)
                    if (hist[k][b] == m_level[b]) all_opp = 1'b0;
                if (all_opp) begin
                    m_level[b] = ~m_level[b];
                    if (m_level[b]) m_rise[b] = 1'b1;
                    else            m_fall[b] = 1'b1;
                end
            end
        end
        exp_q.push_back({m_level, m_rise, m_fall});
    end

    // ---------------- monitor / scoreboard ----------------
    bit mon_on = 1'b0;
    int rise_seen [N];
    int fall_seen [N];

    always @(negedge Clock) begin
        logic [3*N-1:0] e;
        for (int b = 0; b < N; b++) begin
            if (SwRise[b] === 1'b1) rise_seen[b]++;
            if (SwFall[b] === 1'b1) fall_seen[b]++;
        end
        if (mon_on) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty t=%0t got=none expected=entry", $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_switches", Switches, e[3*N-1:2*N]);
                check("sb_rise",     SwRise,   e[2*N-1:N]);
                check("sb_fall",     SwFall,   e[N-1:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [N-1:0] v);
        @(negedge Clock); #1;
        SwIn = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        int r0;
        int r3;
        int f0;
        int p;
        logic [N-1:0] v;
        for (int b = 0; b < N; b++) begin
            rise_seen[b] = 0;
            fall_seen[b] = 0;
        end

        // 1. reset values with all switches high
        nReset = 1'b0;
        SwIn   = 10'h3FF;
        @(posedge Clock); #1;
        mon_on = 1'b1;
        after_edges(3);
        check("reset_switches", Switches, '0);
        check("reset_rise",     SwRise,   '0);
        check("reset_fall",     SwFall,   '0);
        @(negedge Clock); #1;
        SwIn   = '0;
        nReset = 1'b1;
        idle(8);

        // 2. clean rise on bit 8
        drive(10'h100);
        after_edges(5);
        check("rise8_not_yet", Switches, '0);
        after_edges(1);
        check("rise8_level", Switches, 10'h100);
        check("rise8_pulse", SwRise,   10'h100);
        check("rise8_nofall", SwFall,  '0);
        after_edges(1);
        check("rise8_pulse_end", SwRise, '0);
        idle(3);

        // 3. bounce rejection on bit 0
        r0 = rise_seen[0];
        f0 = fall_seen[0];
        for (int c = 0; c < 40; c++) drive({SwIn[N-1:1], ((c / 2) % 2 == 0) ? 1'b1 : 1'b0});
        drive({SwIn[N-1:1], 1'b0});
        idle(10);
        check("bounce0_level", Switches & 10'h001, '0);
        check("bounce0_pulses", N'(rise_seen[0] - r0 + fall_seen[0] - f0), '0);

        // 4. bounce then settle on bit 3
        r3 = rise_seen[3];
        drive(SwIn | 10'h008);
        drive(SwIn & ~10'h008);
        drive(SwIn | 10'h008);
        drive(SwIn & ~10'h008);
        drive(SwIn | 10'h008);
        after_edges(5);
        check("settle3_not_yet", Switches & 10'h008, '0);
        after_edges(1);
        check("settle3_level", Switches & 10'h008, 10'h008);
        check("settle3_pulse", SwRise & 10'h008, 10'h008);
        idle(6);
        check("settle3_one_rise", N'(rise_seen[3] - r3), N'(1));

        // 5. multi-bit fall and rise in one cycle
        drive(10'h0FF);
        idle(10);
        check("multi_start", Switches, 10'h0FF);
        drive(10'h300);
        after_edges(5);
        check("multi_not_yet", Switches, 10'h0FF);
        after_edges(1);
        check("multi_level", Switches, 10'h300);
        check("multi_rise",  SwRise,   10'h300);
        check("multi_fall",  SwFall,   10'h0FF);
        after_edges(1);
        check("multi_rise_end", SwRise, '0);
        check("multi_fall_end", SwFall, '0);
        idle(3);

        // 6. reset in the middle of a count
        drive(10'h320);
        repeat (4) @(posedge Clock);
        @(negedge Clock); #1;
        nReset = 1'b0;
        #1;
        check("midreset_async", Switches, '0);
        repeat (2) @(posedge Clock);
        #1;
        check("midreset_held", Switches, '0);
        @(negedge Clock); #1;
        nReset = 1'b1;
        after_edges(5);
        check("midreset_not_yet", Switches, '0);
        after_edges(1);
        check("midreset_level", Switches, 10'h320);
        check("midreset_rise",  SwRise,   10'h320);
        idle(4);

        // 7. randomized segments of varying bounce intensity with rare resets
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = 2;
                2:       p = 10;
                default: p = 40;
            endcase
            for (int c = 0; c < 50; c++) begin
                v = SwIn;
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, 99) < p) v[b] = ~v[b];
                drive(v);
                if ($urandom_range(0, 499) == 0) begin
                    nReset = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge Clock);
                    #1;
                    nReset = 1'b1;
                end
            end
        end
        idle(12);

        @(negedge Clock); #2;
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
